// File: rtl/calc_ascii_pkg.sv
// Shared definitions for the calculator's ASCII front end (ASCII-to-BCD
// decoder on the receive side, BCD-to-ASCII encoder on the transmit side).
//   - ASCII byte constants used by both directions
//   - encoder FSM state enum
//   - decoder operator codes
//   - idx_width(): width of a digit index for a given digit count
package calc_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ENC_IDLE  = 3'd0,
    ENC_SIGN  = 3'd1,
    ENC_DIGIT = 3'd2,
    ENC_CR    = 3'd3,
    ENC_LF    = 3'd4,
    ENC_ERR   = 3'd5
  } enc_state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011
  } op_e;

  // ceil(log2(digits)), but never narrower than one bit so a single-digit
  // build still has a legal index vector.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_lead_scan.sv
// Combinational scan of a packed BCD value.
//   bcd       : packed BCD, MSD in the top nibble
//   first_idx : index of the most significant nonzero digit (0 when all zero)
//   all_zero  : every nibble is zero
//   invalid   : at least one nibble is greater than 9
module bcd_lead_scan
  import calc_ascii_pkg::*;
#(
  parameter int DIGITS = 12,
  parameter int IDX_W  = idx_width(DIGITS)
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic [IDX_W-1:0]    first_idx,
  output logic                all_zero,
  output logic                invalid
);

  // Walk from the LSD upward; each nonzero digit overwrites the index, so the
  // value left at the end belongs to the most significant nonzero digit.
  always_comb begin
    first_idx = '0;
    all_zero  = 1'b1;
    invalid   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        first_idx = IDX_W'(i);
        all_zero  = 1'b0;
      end
      if (bcd[4*i +: 4] > 4'd9) begin
        invalid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_ascii_encoder.sv
// Streams a packed-BCD result as an ASCII line: optional '-', the digits with
// leading zeros suppressed, then CR LF. An invalid result is sent as "E" CR LF.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : request to send; sampled only while idle
//   res_bcd/neg/err     : result captured on an accepted start
//   tx_data/tx_valid    : byte offered to the sink (registered)
//   tx_ready            : sink accepts the byte this cycle
//   busy                : frame in progress (cycle after start until LF accepted)
//   done                : one-cycle pulse after LF is accepted
//
// Handshake: a byte moves on each rising edge with tx_valid && tx_ready. While
// tx_valid is high and tx_ready low, tx_data holds; tx_valid only falls after a
// transfer (or on reset). tx_ready never reaches tx_valid/tx_data combinationally.
module bcd_ascii_encoder
  import calc_ascii_pkg::*;
#(
  parameter int DIGITS = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] res_bcd,
  input  logic                res_neg,
  input  logic                res_err,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = idx_width(DIGITS);

  enc_state_e          state;
  enc_state_e          nxt_state;
  enc_state_e          load_state;
  logic [4*DIGITS-1:0] held_bcd;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    nxt_idx;
  logic [IDX_W-1:0]    load_idx;
  logic [IDX_W-1:0]    first_idx;
  logic                all_zero;
  logic                invalid;
  logic [3:0]          load_nibble;
  logic [7:0]          load_byte;

  bcd_lead_scan #(
    .DIGITS (DIGITS),
    .IDX_W  (IDX_W)
  ) u_scan (
    .bcd       (res_bcd),
    .first_idx (first_idx),
    .all_zero  (all_zero),
    .invalid   (invalid)
  );

  // Successor of the current byte once it transfers.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    case (state)
      ENC_SIGN:  nxt_state = ENC_DIGIT;
      ENC_DIGIT: begin
        if (idx == '0) nxt_state = ENC_CR;
        else           nxt_idx   = idx - 1'b1;
      end
      ENC_ERR:   nxt_state = ENC_CR;
      ENC_CR:    nxt_state = ENC_LF;
      ENC_LF:    nxt_state = ENC_IDLE;
      default:   nxt_state = state;
    endcase
  end

  // The byte to load into tx_data: the first byte of a frame comes from the
  // current state (tx_valid still low), later bytes from the successor so
  // back-to-back transfers need no bubble.
  assign load_state  = tx_valid ? nxt_state : state;
  assign load_idx    = tx_valid ? nxt_idx   : idx;
  assign load_nibble = held_bcd[{load_idx, 2'b00} +: 4];

  always_comb begin
    load_byte = 8'h00;
    case (load_state)
      ENC_SIGN:  load_byte = ASCII_MINUS;
      ENC_DIGIT: load_byte = {ASCII_ZERO[7:4], load_nibble};
      ENC_ERR:   load_byte = ASCII_E;
      ENC_CR:    load_byte = ASCII_CR;
      ENC_LF:    load_byte = ASCII_LF;
      default:   load_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENC_IDLE;
      held_bcd <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ENC_IDLE) begin
        if (start) begin
          held_bcd <= res_bcd;
          // Leading zeros are skipped by starting at the top nonzero digit;
          // an all-zero value starts (and ends) at digit 0.
          idx      <= first_idx;
          busy     <= 1'b1;
          if (res_err || invalid)        state <= ENC_ERR;
          else if (res_neg && !all_zero) state <= ENC_SIGN;
          else                           state <= ENC_DIGIT;
        end
      end else if (!tx_valid) begin
        tx_valid <= 1'b1;
        tx_data  <= load_byte;
      end else if (tx_ready) begin
        if (state == ENC_LF) begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= ENC_IDLE;
        end else begin
          state   <= nxt_state;
          idx     <= nxt_idx;
          tx_data <= load_byte;
        end
      end
    end
  end

endmodule
